// File: rtl/flash_rom_ctrl_pkg.sv
// Shared types and constants for the boot-ROM flash controller.
// Holds the FSM state encoding and the default geometry of the flash interface.
package flash_rom_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ROM_BYTES_PER_WORD = 4;
    localparam int FLASH_WAIT_DEF     = 2;
    localparam int ADDR_W_DEF         = 24;

endpackage

// File: rtl/flash_rom_buf.sv
// One-word read buffer: valid bit, word tag and 32-bit data with byte-lane fill.
// A fill always wins over a flush so a completing fetch leaves the buffer valid.
module flash_rom_buf
    import flash_rom_ctrl_pkg::*;
#(
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             lane_we_i,
    input  logic [1:0]       lane_i,
    input  logic [7:0]       byte_i,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [8*ROM_BYTES_PER_WORD-1:0] data_o
);

    logic                            valid_q;
    logic [TAG_W-1:0]                tag_q;
    logic [8*ROM_BYTES_PER_WORD-1:0] data_q;

    // Buffer state: byte-lane writes during a fetch, tag/valid on completion, flush clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (fill_i) begin
                valid_q <= 1'b1;
                tag_q   <= fill_tag_i;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
            if (lane_we_i) begin
                case (lane_i)
                    2'd0:    data_q[7:0]   <= byte_i;
                    2'd1:    data_q[15:8]  <= byte_i;
                    2'd2:    data_q[23:16] <= byte_i;
                    2'd3:    data_q[31:24] <= byte_i;
                    default: data_q        <= data_q;
                endcase
            end
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule

// File: rtl/flash_rom_ctrl.sv
// CPU boot-ROM port in front of a byte-wide asynchronous flash.
// Misses assemble a word from four timed byte reads; the result is kept in a one-word buffer.
module flash_rom_ctrl
    import flash_rom_ctrl_pkg::*;
#(
    parameter int FLASH_WAIT = FLASH_WAIT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rom_en,
    input  logic              rom_write_en,
    input  logic [31:0]       rom_addr,
    input  logic [31:0]       rom_write_data,
    input  logic              rom_flush,
    output logic [31:0]       rom_read_data,
    output logic              rom_ready,
    output logic              rom_write_err,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [7:0]        flash_data
);

    localparam int TAG_W = ADDR_W - 2;
    localparam logic [3:0] WAIT_LD  = 4'(FLASH_WAIT);
    localparam logic [1:0] LAST_IDX = 2'(ROM_BYTES_PER_WORD - 1);

    state_e              state_q;
    logic [TAG_W-1:0]    word_q;
    logic [1:0]          byte_idx_q;
    logic [3:0]          wait_cnt_q;
    logic                write_err_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic [ADDR_W-1:0]   flash_addr_q;

    logic [TAG_W-1:0]    req_word_s;
    logic [1:0]          next_idx_s;
    logic                buf_valid_s;
    logic [TAG_W-1:0]    buf_tag_s;
    logic [31:0]         buf_data_s;
    logic                hit_s;
    logic                capture_s;
    logic                last_s;
    logic                flush_s;
    logic                unused_s;

    assign req_word_s = rom_addr[ADDR_W-1:2];
    assign next_idx_s = byte_idx_q + 2'd1;
    assign hit_s      = buf_valid_s && (buf_tag_s == req_word_s);
    assign capture_s  = (state_q == ST_READ) && (wait_cnt_q == 4'd0);
    assign last_s     = capture_s && (byte_idx_q == LAST_IDX);
    // A flush that lands mid-fetch is dropped; the fill re-validates the buffer anyway.
    assign flush_s    = rom_flush && (state_q != ST_READ);
    assign unused_s   = ^{rom_write_data, rom_addr[31:ADDR_W], rom_addr[1:0]};

    flash_rom_buf #(
        .TAG_W (TAG_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_s),
        .lane_we_i  (capture_s),
        .lane_i     (byte_idx_q),
        .byte_i     (flash_data),
        .fill_i     (last_s),
        .fill_tag_i (word_q),
        .valid_o    (buf_valid_s),
        .tag_o      (buf_tag_s),
        .data_o     (buf_data_s)
    );

    // Ready is combinational so a buffer hit costs no stall cycle.
    always_comb begin
        rom_ready = 1'b0;
        case (state_q)
            ST_IDLE: rom_ready = !rom_en || rom_write_en || hit_s;
            ST_READ: rom_ready = 1'b0;
            ST_DONE: rom_ready = rom_en && (buf_tag_s == req_word_s);
            default: rom_ready = 1'b0;
        endcase
    end

    // Main FSM with registered flash strobes, flash address and write-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            byte_idx_q   <= 2'd0;
            wait_cnt_q   <= 4'd0;
            write_err_q  <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            flash_addr_q <= '0;
        end else begin
            write_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rom_en && rom_write_en) begin
                        write_err_q <= 1'b1;
                    end else if (rom_en && !hit_s) begin
                        word_q       <= req_word_s;
                        byte_idx_q   <= 2'd0;
                        wait_cnt_q   <= WAIT_LD;
                        ce_n_q       <= 1'b0;
                        oe_n_q       <= 1'b0;
                        flash_addr_q <= {req_word_s, 2'd0};
                        state_q      <= ST_READ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (wait_cnt_q == 4'd0) begin
                        wait_cnt_q <= WAIT_LD;
                        byte_idx_q <= next_idx_s;
                        if (byte_idx_q == LAST_IDX) begin
                            ce_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            flash_addr_q <= {word_q, next_idx_s};
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_read_data = buf_data_s;
    assign rom_write_err = write_err_q;
    assign flash_ce_n    = ce_n_q;
    assign flash_oe_n    = oe_n_q;
    assign flash_addr    = flash_addr_q;

endmodule
